field_arbiter: RTL and testbench

Message-locked round-robin arbiter that shares the single downstream field bus between the `num_decoders` FAST field decoders. It grants one decoder at a time and holds the grant until that decoder's last field of the current message has been accepted, so fields of one message never interleave with another. It checks the field-index sequence and registers the selected field onto a valid/ready output stage feeding the field FIFO.

---
 rtl/field_arbiter.sv | 167 ++++++++++++++++
 tb/tb_field_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_arbiter.sv
// field_arbiter: message-locked round-robin arbiter driving one registered field bus.
// Define FIELD_ARB_TIMEOUT_EN to release a lock whose owner stalls for timeout_cycles.
module field_arbiter #(
    parameter int num_decoders     = 4,
    parameter int beat_width       = 64,
    parameter int max_message_size = 10,
    parameter int messageID_size   = 21,
    parameter int timeout_cycles   = 16,
    localparam int IDX_W = $clog2(max_message_size),
    localparam int W     = 2 + messageID_size + IDX_W + beat_width,
    localparam int SRC_W = $clog2(num_decoders)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_decoders-1:0][W-1:0] in_fields,
    output logic [num_decoders-1:0]        in_ready,
    output logic [W-1:0]                   out_field,
    output logic [SRC_W-1:0]               out_src,
    input  logic                           out_ready,
    output logic                           seq_err,
    output logic                           ovf_err,
    output logic                           timeout_err,
    output logic [15:0]                    msg_count
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam int unsigned    ND    = num_decoders;
    localparam logic [SRC_W:0] ND_W  = (SRC_W+1)'(num_decoders);
    localparam logic [IDX_W:0] MAX_W = (IDX_W+1)'(max_message_size);

    logic [0:0]              state;
    logic [SRC_W-1:0]        grant;
    logic [SRC_W-1:0]        rr_ptr;
    logic [IDX_W:0]          exp_idx;

    logic [num_decoders-1:0] req;
    logic [W-1:0]            sel_field;
    logic                    sel_req;
    logic                    sel_last;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W:0]          next_idx;
    logic                    out_free;
    logic                    accept;
    logic                    found;
    logic [SRC_W-1:0]        pick;
    logic [SRC_W:0]          cand;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            req[i] = in_fields[i][W-1];
        end
    end

    assign sel_field = in_fields[grant];
    assign sel_req   = sel_field[W-1];
    assign sel_last  = sel_field[W-2];
    assign sel_idx   = sel_field[beat_width +: IDX_W];
    assign next_idx  = {1'b0, sel_idx} + (IDX_W+1)'(1);
    assign out_free  = !out_field[W-1] || out_ready;
    assign accept    = (state == LOCKED) && sel_req && out_free;

    always_comb begin
        in_ready = '0;
        if (state == LOCKED) begin
            in_ready[grant] = out_free;
        end
    end

    // First requester at or after rr_ptr, wrapping modulo num_decoders.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (cand >= ND_W) begin
                cand = cand - ND_W;
            end
            if (!found && req[cand[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[SRC_W-1:0];
            end
        end
    end

`ifdef FIELD_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(timeout_cycles + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;

    assign stall_hit = (state == LOCKED) && !sel_req &&
                       (stall_cnt == STALL_W'(timeout_cycles - 1));
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            exp_idx   <= '0;
            out_field <= '0;
            out_src   <= '0;
            seq_err   <= 1'b0;
            ovf_err   <= 1'b0;
            msg_count <= '0;
`ifdef FIELD_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            seq_err <= 1'b0;
            ovf_err <= 1'b0;
`ifdef FIELD_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            if (state != LOCKED || accept || stall_hit) begin
                stall_cnt <= '0;
            end else if (!sel_req) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
`endif
            if (accept) begin
                out_field <= sel_field;
                out_src   <= grant;
                seq_err   <= ({1'b0, sel_idx} != exp_idx);
                exp_idx   <= next_idx;
            end else if (out_ready) begin
                out_field[W-1] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= pick;
                        rr_ptr  <= (pick == SRC_W'(num_decoders - 1)) ? '0 : pick + 1'b1;
                        exp_idx <= '0;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (sel_last) begin
                            msg_count <= msg_count + 16'd1;
                            state     <= IDLE;
                        end else if (next_idx >= MAX_W) begin
                            ovf_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
`ifdef FIELD_ARB_TIMEOUT_EN
                    else if (stall_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_field_arbiter.sv
// tb_field_arbiter: directed stimulus queues expected words in arbitration order;
// a negedge monitor pops and compares every output handshake.
`timescale 1ns/1ps
module tb_field_arbiter;

    localparam int ND    = 4;
    localparam int BW    = 64;
    localparam int MMS   = 10;
    localparam int IDW   = 21;
    localparam int TO    = 16;
    localparam int IDX_W = $clog2(MMS);
    localparam int W     = 2 + IDW + IDX_W + BW;
    localparam int SRC_W = $clog2(ND);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ND-1:0][W-1:0] in_fields;
    logic [ND-1:0]        in_ready;
    logic [W-1:0]         out_field;
    logic [SRC_W-1:0]     out_src;
    logic                 out_ready = 1'b1;
    logic                 seq_err;
    logic                 ovf_err;
    logic                 timeout_err;
    logic [15:0]          msg_count;

    field_arbiter #(
        .num_decoders    (ND),
        .beat_width      (BW),
        .max_message_size(MMS),
        .messageID_size  (IDW),
        .timeout_cycles  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_fields  (in_fields),
        .in_ready   (in_ready),
        .out_field  (out_field),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err),
        .timeout_err(timeout_err),
        .msg_count  (msg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     word;
        logic [SRC_W-1:0] src;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  dq[ND][$];
    logic [ND-1:0] acc;
    int            hs_cyc[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, seq_cnt = 0, ovf_cnt = 0, tmo_cnt = 0;
    int seq_idx = -1, ovf_idx = -1;
    logic [ND-1:0] ovf_rdy = '1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic last, input int id, input int idx);
        return {1'b1, last, IDW'(id), IDX_W'(idx), 32'hC0DE_F00D, 16'(id), 16'(idx)};
    endfunction

    task automatic put(input int dec, input logic [W-1:0] w);
        exp_t e;
        e.word = w;
        e.src  = SRC_W'(dec);
        dq[dec].push_back(w);
        sb.push_back(e);
    endtask

    task automatic msg(input int dec, input int id, input int n, input bit term);
        for (int k = 0; k < n; k++) put(dec, mk(term && (k == n - 1), id, k));
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain"}, 128'(sb.size()), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_q(input int d, input int n, input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (dq[d].size() != n && t < 100);
        check(name, 128'(dq[d].size()), 128'(n));
    endtask

    // Decoder models: present queue heads, retire a head once it was accepted.
    initial begin
        in_fields = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) acc[i] = in_fields[i][W-1] && in_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < ND; i++) begin
                if (rst) dq[i].delete();
                else if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
                in_fields[i] = (dq[i].size() > 0) ? dq[i][0] : '0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
            end else begin
                if (out_field[W-1] && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got %0h, expected no output", out_field);
                    end else begin
                        e = sb.pop_front();
                        check("out_field", 128'(out_field), 128'(e.word));
                        check("out_src", 128'(out_src), 128'(e.src));
                        hs_cyc.push_back(cyc);
                    end
                end
                if (seq_err) begin
                    seq_cnt++;
                    seq_idx = int'(out_field[BW +: IDX_W]);
                end
                if (ovf_err) begin
                    ovf_cnt++;
                    ovf_idx = int'(out_field[BW +: IDX_W]);
                    ovf_rdy = in_ready;
                end
                if (timeout_err) tmo_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] held;
        repeat (3) @(negedge clk);
        check("rst_out_field", 128'(out_field), 128'(0));
        check("rst_out_src", 128'(out_src), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_msg_count", 128'(msg_count), 128'(0));
        check("rst_errs", 128'({seq_err, ovf_err, timeout_err}), 128'(0));
        rst = 1'b0;

        // Two 3-field messages: decoder 0 wins, one bubble, then decoder 2.
        hs_cyc.delete();
        msg(0, 1, 3, 1);
        msg(2, 2, 3, 1);
        drain("t1");
        check("t1_hs_n", 128'(hs_cyc.size()), 128'(6));
        if (hs_cyc.size() == 6) begin
            check("t1_gap01", 128'(hs_cyc[1] - hs_cyc[0]), 128'(1));
            check("t1_gap12", 128'(hs_cyc[2] - hs_cyc[1]), 128'(1));
            check("t1_bubble", 128'(hs_cyc[3] - hs_cyc[2]), 128'(2));
            check("t1_gap34", 128'(hs_cyc[4] - hs_cyc[3]), 128'(1));
        end
        check("t1_msg_count", 128'(msg_count), 128'(2));
        check("t1_errs", 128'(seq_cnt + ovf_cnt), 128'(0));

        // rr_ptr is 3 now; decoder 3 brings it back to 0.
        msg(3, 3, 1, 1);
        drain("t1b");

        // All four requesting 1-field messages: grants 0,1,2,3,0.
        msg(0, 4, 1, 1);
        msg(1, 5, 1, 1);
        msg(2, 6, 1, 1);
        msg(3, 7, 1, 1);
        msg(0, 8, 1, 1);
        drain("t2");
        check("t2_msg_count", 128'(msg_count), 128'(8));

        // Downstream stall for 5 cycles mid-message.
        msg(1, 9, 5, 1);
        wait_q(1, 3, "t3_reach");
        @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        held = out_field;
        check("t3_stall_valid", 128'(out_field[W-1]), 128'(1));
        check("t3_stall_ready0", 128'(in_ready), 128'(0));
        repeat (4) begin
            @(negedge clk);
            check("t3_stall_hold", 128'(out_field), 128'(held));
            check("t3_stall_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain("t3");
        check("t3_msg_count", 128'(msg_count), 128'(9));

        // Index sequence 0,2,3: one seq_err alongside the idx-2 word.
        put(2, mk(0, 10, 0));
        put(2, mk(0, 10, 2));
        put(2, mk(1, 10, 3));
        drain("t4");
        check("t4_seq_cnt", 128'(seq_cnt), 128'(1));
        check("t4_seq_idx", 128'(seq_idx), 128'(2));
        check("t4_msg_count", 128'(msg_count), 128'(10));

        // 10 fields without last: overflow after the 10th, lock dropped.
        msg(3, 11, 10, 0);
        drain("t5");
        check("t5_ovf_cnt", 128'(ovf_cnt), 128'(1));
        check("t5_ovf_idx", 128'(ovf_idx), 128'(9));
        check("t5_ovf_idle", 128'(ovf_rdy), 128'(0));
        check("t5_msg_count", 128'(msg_count), 128'(10));
        msg(3, 12, 1, 1);
        drain("t5b");
        check("t5b_seq_cnt", 128'(seq_cnt), 128'(1));
        check("t5b_msg_count", 128'(msg_count), 128'(11));

        // Reset while locked mid-message.
        msg(0, 13, 5, 1);
        wait_q(0, 3, "t6_reach");
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_out_field", 128'(out_field), 128'(0));
        check("t6_out_src", 128'(out_src), 128'(0));
        check("t6_in_ready", 128'(in_ready), 128'(0));
        check("t6_msg_count", 128'(msg_count), 128'(0));
        check("t6_errs", 128'({seq_err, ovf_err, timeout_err}), 128'(0));
        check("t6_rr_ptr", 128'(dut.rr_ptr), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FIELD_ARB_TIMEOUT_EN
        // Decoder 1 locks then goes silent; decoder 2 is granted after the timeout.
        msg(1, 14, 2, 0);
        msg(2, 15, 1, 1);
        drain("t7");
        check("t7_tmo_cnt", 128'(tmo_cnt), 128'(1));
        check("t7_msg_count", 128'(msg_count), 128'(1));
`else
        msg(1, 14, 1, 1);
        drain("t7");
        check("t7_tmo_cnt", 128'(tmo_cnt), 128'(0));
        check("t7_msg_count", 128'(msg_count), 128'(1));
`endif
        check("final_seq_cnt", 128'(seq_cnt), 128'(1));
        check("final_ovf_cnt", 128'(ovf_cnt), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
